uart_baud_tick_gen: RTL and testbench

// - Parametrised successor to the fixed UART baud generator.
// - Produces a one-cycle oversample tick (Rx_Tick) for the receiver and a one-cycle bit tick (Tx_Tick) for the transmitter.
// - Also produces a square-wave Baud_Clk for debug and legacy use.
// - Divisor has integer and fractional parts, is run-time programmable, and reloads glitch-free only on bit boundaries.
// - Sits between the system clock and the UART TX/RX engines.

---
 rtl/uart_baud_tick_gen_pkg.sv | 11 +
 rtl/uart_baud_tick_gen_frac_prescaler.sv | 61 ++++++
 rtl/uart_baud_tick_gen.sv | 49 ++++
 tb/tb_uart_baud_tick_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_baud_tick_gen_pkg.sv
// uart_baud_tick_gen_pkg: shared widths, oversample ratio and standard-baud divisors for a 50 MHz clock
package uart_baud_tick_gen_pkg;
  localparam int INT_W_DEF = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int MIN_DIV = 2;
  localparam int unsigned DIV_INT_115200 = 27;
  localparam int unsigned DIV_FRAC_115200 = 2;
  localparam int unsigned DIV_INT_9600 = 325;
  localparam int unsigned DIV_FRAC_9600 = 8;
endpackage

// File: rtl/uart_baud_tick_gen_frac_prescaler.sv
// uart_baud_tick_gen_frac_prescaler: fractional-N prescaler emitting the oversample tick and staging divisor reloads
module uart_baud_tick_gen_frac_prescaler
  import uart_baud_tick_gen_pkg::*;
#(
  parameter int INT_W = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int unsigned DEFAULT_INT = DIV_INT_115200,
  parameter int unsigned DEFAULT_FRAC = DIV_FRAC_115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bit_end,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_pending,
  output logic              rx_tick
);
  logic [INT_W-1:0] act_int, pend_int, new_int;
  logic [FRAC_W-1:0] act_frac, pend_frac, acc;
  logic [INT_W:0] pre_cnt, last_cnt;
  logic [FRAC_W:0] acc_sum;
  logic carry, wrap, apply;
  always_comb begin
    new_int = div_int < INT_W'(MIN_DIV) ? INT_W'(MIN_DIV) : div_int;
    last_cnt = {1'b0, act_int} - {{INT_W{1'b0}}, ~carry};
    wrap = en && pre_cnt == last_cnt;
    acc_sum = {1'b0, acc} + {1'b0, act_frac};
    apply = (div_load || div_pending) && (bit_end || !en);
  end
  // a load arriving on the boundary wins over the staged value
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      acc <= '0;
      carry <= 1'b0;
      rx_tick <= 1'b0;
      div_pending <= 1'b0;
      act_int <= INT_W'(DEFAULT_INT);
      act_frac <= FRAC_W'(DEFAULT_FRAC);
      pend_int <= '0;
      pend_frac <= '0;
    end else begin
      rx_tick <= wrap;
      pre_cnt <= (!en || wrap) ? '0 : pre_cnt + (INT_W+1)'(1);
      if (!en) {carry, acc} <= '0;
      else if (wrap) {carry, acc} <= acc_sum;
      else if (apply) acc <= '0;
      if (apply) begin
        act_int <= div_load ? new_int : pend_int;
        act_frac <= div_load ? div_frac : pend_frac;
      end
      if (div_load) begin
        pend_int <= new_int;
        pend_frac <= div_frac;
      end
      div_pending <= (div_pending || div_load) && !apply;
    end
  end
endmodule

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen: fractional UART baud generator with oversample tick, bit tick and square-wave baud clock
module uart_baud_tick_gen
  import uart_baud_tick_gen_pkg::*;
#(
  parameter int INT_W = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DEFAULT_INT = DIV_INT_115200,
  parameter int unsigned DEFAULT_FRAC = DIV_FRAC_115200
) (
  input  logic              Clock_In,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [INT_W-1:0]  Div_Int,
  input  logic [FRAC_W-1:0] Div_Frac,
  input  logic              Div_Load,
  output logic              Div_Pending,
  output logic              Rx_Tick,
  output logic              Tx_Tick,
  output logic              Baud_Clk
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  logic [OS_W-1:0] os_cnt;
  uart_baud_tick_gen_frac_prescaler #(
    .INT_W(INT_W),
    .FRAC_W(FRAC_W),
    .DEFAULT_INT(DEFAULT_INT),
    .DEFAULT_FRAC(DEFAULT_FRAC)
  ) u_pre (
    .clk(Clock_In),
    .rst(Reset),
    .en(Enable),
    .bit_end(Tx_Tick),
    .div_int(Div_Int),
    .div_frac(Div_Frac),
    .div_load(Div_Load),
    .div_pending(Div_Pending),
    .rx_tick(Rx_Tick)
  );
  always_ff @(posedge Clock_In) begin
    if (Reset || !Enable) os_cnt <= '0;
    else if (Rx_Tick) os_cnt <= os_cnt == OS_W'(OVERSAMPLE - 1) ? '0 : os_cnt + OS_W'(1);
  end
  // Baud_Clk rises halfway through the bit so a sampler can use its edge mid-bit
  always_comb begin
    Tx_Tick = Rx_Tick && os_cnt == OS_W'(OVERSAMPLE - 1);
    Baud_Clk = os_cnt >= OS_W'(OVERSAMPLE / 2);
  end
endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// tb_uart_baud_tick_gen: directed timing checks plus randomized run against a time-based reference model
module tb_uart_baud_tick_gen;
  localparam int OS = 16, DI = 27, DF = 2, IW = 16, FW = 4;
  logic clk = 0, rst = 1, en = 0, div_load = 0;
  logic [IW-1:0] div_int = '0;
  logic [FW-1:0] div_frac = '0;
  logic rx_tick, tx_tick, baud_clk, div_pending;
  logic rst4 = 1, en4 = 0, rx4, tx4, baud4, pend4;
  int total = 0, bad = 0, cyc = 0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_baud_tick_gen u_dut (
    .Clock_In(clk), .Reset(rst), .Enable(en), .Div_Int(div_int), .Div_Frac(div_frac),
    .Div_Load(div_load), .Div_Pending(div_pending), .Rx_Tick(rx_tick), .Tx_Tick(tx_tick), .Baud_Clk(baud_clk)
  );
  uart_baud_tick_gen #(.OVERSAMPLE(4), .DEFAULT_INT(2), .DEFAULT_FRAC(0)) u_os4 (
    .Clock_In(clk), .Reset(rst4), .Enable(en4), .Div_Int('0), .Div_Frac('0),
    .Div_Load(1'b0), .Div_Pending(pend4), .Rx_Tick(rx4), .Tx_Tick(tx4), .Baud_Clk(baud4)
  );
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic wait_sig(input int which, input int lim);
    int t0;
    logic hit;
    t0 = cyc;
    hit = 1'b0;
    while (!hit && cyc - t0 < lim) begin
      @(negedge clk);
      hit = which == 0 ? rx_tick : which == 1 ? tx_tick : tx4;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_%0d: no tick within %0d cycles, want one", which, lim);
    end
  endtask
  // reference model: a tick is due act_int+ext cycles after the previous one (absolute time)
  int m_int = DI, m_frac = DF, p_int = 0, p_frac = 0, m_acc = 0, m_ext = 0, m_last = 0, m_n = 0, mcyc = 0, s = 0;
  bit m_pend = 0, m_run = 0, bnd = 0, exp_rx = 0, exp_tx = 0, exp_baud = 0, exp_pend = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_int = DI; m_frac = DF; m_pend = 0; m_acc = 0; m_ext = 0; m_run = 0; m_n = 0;
      exp_rx = 0; exp_tx = 0; exp_baud = 0; exp_pend = 0;
    end else begin
      bnd = exp_tx || !en;
      if (exp_rx) m_n = (m_n + 1) % OS;
      if ((div_load || m_pend) && bnd) begin
        m_int = div_load ? (div_int < 2 ? 2 : int'(div_int)) : p_int;
        m_frac = div_load ? int'(div_frac) : p_frac;
        m_pend = 0;
        m_acc = 0;
      end else if (div_load) begin
        p_int = div_int < 2 ? 2 : int'(div_int);
        p_frac = int'(div_frac);
        m_pend = 1;
      end
      if (!en) begin
        m_n = 0; m_acc = 0; m_ext = 0; m_run = 0; exp_rx = 0;
      end else begin
        if (!m_run) begin
          m_run = 1;
          m_last = mcyc - 1;
        end
        exp_rx = mcyc == m_last + m_int + m_ext;
        if (exp_rx) begin
          s = m_acc + m_frac;
          m_ext = s / (1 << FW);
          m_acc = s % (1 << FW);
          m_last = mcyc;
        end
      end
      exp_tx = exp_rx && m_n == OS - 1;
      exp_baud = m_n >= OS / 2;
      exp_pend = m_pend;
    end
    mcyc++;
  end
  always @(negedge clk) begin
    check("rx", int'(rx_tick), int'(exp_rx));
    check("tx", int'(tx_tick), int'(exp_tx));
    check("baud", int'(baud_clk), int'(exp_baud));
    check("pend", int'(div_pending), int'(exp_pend));
  end
  initial begin
    int c0, t, p, n, k;
    repeat (3) @(negedge clk);
    check("reset_outs", int'({rx_tick, tx_tick, baud_clk, div_pending}), 0);
    rst4 = 0;
    en4 = 1;
    wait_sig(2, 100);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      k = (i - 1) % 8 + 1;
      check("os4_rx", int'(rx4), int'(k % 2 == 0));
      check("os4_tx", int'(tx4), int'(k == 8));
      check("os4_baud", int'(baud4), int'(k >= 5));
    end
    check("os4_pend", int'(pend4), 0);
    en4 = 0;
    rst = 0;
    en = 1;
    c0 = cyc;
    wait_sig(0, 100);
    check("first_rx", cyc - c0, 27);
    wait_sig(1, 1000);
    t = cyc;
    p = cyc;
    k = 0;
    repeat (16) begin
      wait_sig(0, 100);
      k += int'(cyc - p == 28);
      p = cyc;
    end
    check("bit_len", cyc - t, 434);
    check("long_periods", k, 2);
    check("tx_on_16th", int'(tx_tick), 1);
    t = cyc;
    repeat (100) @(negedge clk);
    div_int = 54;
    div_frac = 4;
    div_load = 1;
    @(negedge clk);
    div_load = 0;
    check("pend_set", int'(div_pending), 1);
    wait_sig(1, 1000);
    check("old_bit_len", cyc - t, 434);
    check("pend_at_tx", int'(div_pending), 1);
    t = cyc;
    @(negedge clk);
    check("pend_clr", int'(div_pending), 0);
    wait_sig(1, 2000);
    check("new_bit_len", cyc - t, 868);
    div_int = 1;
    div_frac = 0;
    div_load = 1;
    @(negedge clk);
    div_load = 0;
    check("pend_coincident", int'(div_pending), 0);
    wait_sig(0, 100);
    p = cyc;
    wait_sig(0, 100);
    check("clamped_period", cyc - p, 2);
    wait_sig(1, 200);
    repeat (7) @(negedge clk);
    en = 0;
    repeat (5) begin
      @(negedge clk);
      check("dis_quiet", int'({rx_tick, tx_tick, baud_clk}), 0);
    end
    en = 1;
    c0 = cyc;
    wait_sig(0, 100);
    check("reen_first_rx", cyc - c0, 2);
    n = 1;
    while (!tx_tick && n < 40) begin
      wait_sig(0, 100);
      n++;
    end
    check("reen_tx_at_16", n, 16);
    repeat (5) @(negedge clk);
    div_int = 100;
    div_frac = 3;
    div_load = 1;
    @(negedge clk);
    div_load = 0;
    check("pend_before_rst", int'(div_pending), 1);
    rst = 1;
    @(negedge clk);
    check("rst_outs", int'({rx_tick, tx_tick, baud_clk, div_pending}), 0);
    rst = 0;
    c0 = cyc;
    wait_sig(0, 200);
    check("rst_default_rx", cyc - c0, 27);
    check("rst_pend_gone", int'(div_pending), 0);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 799) == 0;
      en = $urandom_range(0, 299) != 0;
      div_load = $urandom_range(0, 29) == 0;
      div_int = IW'($urandom_range(0, 6));
      div_frac = FW'($urandom);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
